pwm_bank: RTL and testbench

PWM_BANK -- requirements
Module: pwm_bank

---
 rtl/pwm_bank_if.sv | 22 ++
 rtl/pwm_bank.sv | 209 ++++++++++++++++++++
 tb/tb_pwm_bank.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/pwm_bank_if.sv
// Byte-stream and frame-status bundle between a UART receiver and pwm_bank.
// The master side feeds received bytes; the slave side is the PWM bank.
interface pwm_bank_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_ok;
  logic       frame_err;

  modport master (
    output rx_data,
    output rx_valid,
    input  frame_ok,
    input  frame_err
  );

  modport slave (
    input  rx_data,
    input  rx_valid,
    output frame_ok,
    output frame_err
  );
endinterface

// File: rtl/pwm_bank.sv
// Bank of N_CH PWM generators configured by 8-byte UART frames.
// Frame: {dev,ch}, period[23:0] MSB first, high time[23:0] MSB first, 8'hFF.
// Unicast frames update one channel at its next period boundary; a
// broadcast (ch=4'hF) reloads every channel at once, phase-aligned.
module pwm_bank #(
  parameter int N_CH   = 4,
  parameter int CW     = 24,
  parameter int DEV_ID = 0,
  parameter int P_DEF  = 50000,
  parameter int D_DEF  = 1000,
  parameter int TO_CYC = 500000
) (
  input  logic            SCLOCK,
  input  logic            RESET,
  pwm_bank_if.slave       bus,
  output logic [N_CH-1:0] pwm
);

  typedef enum logic [1:0] {S_ADDR, S_PER, S_DUTY, S_TERM} state_t;

  localparam int              TO_W    = $clog2(TO_CYC + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TO_CYC - 1);
  localparam logic [TO_W-1:0] TO_ONE  = TO_W'(1);
  localparam logic [CW-1:0]   ONE     = CW'(1);
  localparam logic [CW-1:0]   ZERO    = '0;
  localparam logic [CW-1:0]   P_INIT  = CW'(P_DEF);
  localparam logic [CW-1:0]   D_INIT  = CW'(D_DEF);
  localparam logic [3:0]      DEV     = 4'(DEV_ID);
  localparam logic [4:0]      CH_LIM  = 5'(N_CH);

  // Parser state
  state_t          state, state_n;
  logic [1:0]      idx, idx_n;
  logic [3:0]      dev, ch;
  logic [23:0]     per_sr, duty_sr;
  logic [TO_W-1:0] tcnt;
  logic            term_ok, term_bad, expire;
  logic            hit, uni, bcast;
  logic            restart;

  // Channel state
  logic [CW-1:0]   cnt      [N_CH];
  logic [CW-1:0]   per_act  [N_CH];
  logic [CW-1:0]   high_act [N_CH];
  logic [CW-1:0]   per_pend [N_CH];
  logic [CW-1:0]   high_pend[N_CH];
  logic [N_CH-1:0] pend;
  logic [N_CH-1:0] wrap;
  logic [N_CH-1:0] load;

  // Parser next-state: one byte per rx_valid; inter-byte timeout loses to a byte.
  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned; a missing default infers a latch.
  always_comb begin
    state_n  = state;
    idx_n    = idx;
    term_ok  = 1'b0;
    term_bad = 1'b0;
    expire   = 1'b0;
    if (bus.rx_valid) begin
      case (state)
        S_ADDR: begin
          state_n = S_PER;
          idx_n   = 2'd0;
        end
        S_PER: begin
          if (idx == 2'd2) begin
            state_n = S_DUTY;
            idx_n   = 2'd0;
          end else begin
            idx_n = idx + 2'd1;
          end
        end
        S_DUTY: begin
          if (idx == 2'd2) begin
            state_n = S_TERM;
            idx_n   = 2'd0;
          end else begin
            idx_n = idx + 2'd1;
          end
        end
        S_TERM: begin
          state_n = S_ADDR;
          idx_n   = 2'd0;
          if (bus.rx_data == 8'hFF) term_ok = 1'b1;
          else                      term_bad = 1'b1;
        end
        default: begin
          state_n = S_ADDR;
          idx_n   = 2'd0;
        end
      endcase
    end else if (state != S_ADDR && tcnt == TO_LAST) begin
      expire  = 1'b1;
      state_n = S_ADDR;
      idx_n   = 2'd0;
    end
  end

  // Parser state register
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge SCLOCK) begin
    if (RESET) begin
      state <= S_ADDR;
      idx   <= 2'd0;
    end else begin
      state <= state_n;
      idx   <= idx_n;
    end
  end

  // Field capture and inter-byte timeout counter
  always_ff @(posedge SCLOCK) begin
    if (RESET) begin
      dev     <= 4'd0;
      ch      <= 4'd0;
      per_sr  <= '0;
      duty_sr <= '0;
      tcnt    <= '0;
    end else begin
      if (bus.rx_valid || state == S_ADDR || expire) tcnt <= '0;
      else                                           tcnt <= tcnt + TO_ONE;
      if (bus.rx_valid) begin
        case (state)
          S_ADDR:  {dev, ch} <= bus.rx_data;
          S_PER:   per_sr    <= {per_sr[15:0], bus.rx_data};
          S_DUTY:  duty_sr   <= {duty_sr[15:0], bus.rx_data};
          default: ;
        endcase
      end
    end
  end

  // Frame decode: frames for other devices or absent channels are dropped silently
  always_comb begin
    hit   = term_ok && (dev == DEV);
    uni   = hit && ({1'b0, ch} < CH_LIM);
    bcast = hit && (ch == 4'hF);
  end

  // Status pulses and the broadcast restart request
  always_ff @(posedge SCLOCK) begin
    if (RESET) begin
      bus.frame_ok  <= 1'b0;
      bus.frame_err <= 1'b0;
      restart       <= 1'b0;
    end else begin
      bus.frame_ok  <= uni || bcast;
      bus.frame_err <= term_bad || expire;
      restart       <= bcast;
    end
  end

  // Per-channel period boundary and load decisions
  always_comb begin
    wrap = '0;
    load = '0;
    for (int i = 0; i < N_CH; i++) begin
      wrap[i] = (per_act[i] != ZERO) && (cnt[i] == per_act[i] - ONE);
      load[i] = restart || (pend[i] && (wrap[i] || per_act[i] == ZERO));
    end
  end

  // Pending registers: a newer frame overwrites values not yet applied
  // NOTE: these register arrays are flops, not RAM, so each element is reset.
  always_ff @(posedge SCLOCK) begin
    if (RESET) begin
      pend <= '0;
      for (int i = 0; i < N_CH; i++) begin
        per_pend[i]  <= P_INIT;
        high_pend[i] <= D_INIT;
      end
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (bcast || (uni && ch == 4'(i))) begin
          per_pend[i]  <= per_sr[CW-1:0];
          high_pend[i] <= duty_sr[CW-1:0];
          pend[i]      <= uni;
        end else if (load[i]) begin
          pend[i] <= 1'b0;
        end
      end
    end
  end

  // Channel counters, glitch-free reload, and registered outputs
  always_ff @(posedge SCLOCK) begin
    if (RESET) begin
      pwm <= '0;
      for (int i = 0; i < N_CH; i++) begin
        cnt[i]      <= ZERO;
        per_act[i]  <= P_INIT;
        high_act[i] <= D_INIT;
      end
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        pwm[i] <= (per_act[i] != ZERO) && (cnt[i] < high_act[i]);
        if (load[i]) begin
          per_act[i]  <= per_pend[i];
          high_act[i] <= high_pend[i];
        end
        if (restart || wrap[i] || per_act[i] == ZERO) cnt[i] <= ZERO;
        else                                           cnt[i] <= cnt[i] + ONE;
      end
    end
  end

endmodule

// File: tb/tb_pwm_bank.sv
// Directed bench for pwm_bank: defaults, unicast/broadcast updates, bad
// terminator, foreign device, timeout, duty boundaries, reset mid-frame.
module tb_pwm_bank;
  localparam int N_CH   = 4;
  localparam int CW     = 24;
  localparam int TO_CYC = 40;
  localparam int BUDGET = 60000;

  logic            sclock = 1'b0;
  logic            reset  = 1'b1;
  logic [N_CH-1:0] pwm;
  int              checks   = 0;
  int              failures = 0;
  int              cyc      = 0;
  int              hi, lo, t0, n;
  logic [7:0]      pat;
  logic            err_seen;

  pwm_bank_if bus ();

  pwm_bank #(
    .N_CH(N_CH), .CW(CW), .DEV_ID(0), .P_DEF(50000), .D_DEF(1000), .TO_CYC(TO_CYC)
  ) dut (
    .SCLOCK(sclock),
    .RESET (reset),
    .bus   (bus),
    .pwm   (pwm)
  );

  always #5 sclock = ~sclock;

  task automatic tick();
    @(posedge sclock);
    #1;
    cyc++;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    tick();
    bus.rx_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [63:0] f);
    for (int k = 7; k >= 0; k--) send_byte(f[k*8 +: 8]);
  endtask

  task automatic wait_level(input int ch, input logic val);
    int w;
    w = 0;
    while (pwm[ch] !== val && w < BUDGET) begin
      tick();
      w++;
    end
    if (pwm[ch] !== val) check($sformatf("wait_ch%0d", ch), 32'(pwm[ch]), 32'(val));
  endtask

  // Full high and low durations of one clean period, starting at a rising edge.
  task automatic measure(input int ch, output int h, output int l);
    int ts;
    wait_level(ch, 1'b0);
    wait_level(ch, 1'b1);
    ts = cyc;
    wait_level(ch, 1'b0);
    h  = cyc - ts;
    ts = cyc;
    wait_level(ch, 1'b1);
    l  = cyc - ts;
  endtask

  task automatic count_level(input int ch, input logic val, input int len, output int hits);
    hits = 0;
    for (int k = 0; k < len; k++) begin
      tick();
      if (pwm[ch] === val) hits++;
    end
  endtask

  initial begin
    bus.rx_data  = 8'h00;
    bus.rx_valid = 1'b0;

    // Reset state
    tick(); tick(); tick();
    check("rst_pwm", 32'(pwm), 32'd0);
    check("rst_ok", 32'(bus.frame_ok), 32'd0);
    check("rst_err", 32'(bus.frame_err), 32'd0);

    // Defaults: all channels start high on the first edge after release
    reset = 1'b0;
    cyc   = 0;
    tick();
    check("dflt_start", 32'(pwm), 32'hF);
    wait_level(0, 1'b0);
    check("dflt_high", 32'(cyc - 1), 32'd1000);
    check("dflt_all_low", 32'(pwm), 32'h0);
    t0 = cyc;

    // Unicast ch0 mid-period: old waveform runs to the period end
    send_frame(64'h00_000064_000019_FF);
    check("uni_ok", 32'(bus.frame_ok), 32'd1);
    check("uni_err", 32'(bus.frame_err), 32'd0);
    tick();
    check("uni_ok_pulse", 32'(bus.frame_ok), 32'd0);
    wait_level(0, 1'b1);
    check("dflt_low", 32'(cyc - t0), 32'd49000);
    check("dflt_period_all", 32'(pwm), 32'hF);
    t0 = cyc;
    wait_level(0, 1'b0);
    check("uni_high", 32'(cyc - t0), 32'd25);
    check("uni_others_kept", 32'(pwm[3:1]), 32'h7);
    t0 = cyc;
    wait_level(0, 1'b1);
    check("uni_low", 32'(cyc - t0), 32'd75);

    // Broadcast: every channel restarts together with period 200, high 100
    send_frame(64'h0F_0000C8_000064_FF);
    check("bc_ok", 32'(bus.frame_ok), 32'd1);
    tick();
    check("bc_ok_pulse", 32'(bus.frame_ok), 32'd0);
    tick();
    check("bc_rise_all", 32'(pwm), 32'hF);
    t0 = cyc;
    wait_level(0, 1'b0);
    check("bc_high", 32'(cyc - t0), 32'd100);
    check("bc_fall_all", 32'(pwm), 32'h0);
    t0 = cyc;
    wait_level(0, 1'b1);
    check("bc_low", 32'(cyc - t0), 32'd100);
    check("bc_rise2_all", 32'(pwm), 32'hF);

    // Bad terminator -> frame_err; foreign device and absent channel -> silence
    send_frame(64'h00_000100_000010_FE);
    check("bad_err", 32'(bus.frame_err), 32'd1);
    check("bad_ok", 32'(bus.frame_ok), 32'd0);
    tick();
    check("bad_err_pulse", 32'(bus.frame_err), 32'd0);
    send_frame(64'h10_00000A_000005_FF);
    check("dev_ok", 32'(bus.frame_ok), 32'd0);
    check("dev_err", 32'(bus.frame_err), 32'd0);
    send_frame(64'h05_00000A_000005_FF);
    check("ch5_ok", 32'(bus.frame_ok), 32'd0);
    check("ch5_err", 32'(bus.frame_err), 32'd0);
    measure(0, hi, lo);
    check("ignored_high", 32'(hi), 32'd100);
    check("ignored_low", 32'(lo), 32'd100);

    // Two frames within one period: the second overwrites the first
    send_frame(64'h00_000032_00000A_FF);
    send_frame(64'h00_00001E_00000F_FF);
    measure(0, hi, lo);
    check("ovr_high", 32'(hi), 32'd15);
    check("ovr_low", 32'(lo), 32'd15);

    // Timeout after three bytes
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    err_seen = 1'b0;
    for (int k = 0; k < TO_CYC - 1; k++) begin
      tick();
      if (bus.frame_err) err_seen = 1'b1;
    end
    check("to_early", 32'(err_seen), 32'd0);
    tick();
    check("to_expire", 32'(bus.frame_err), 32'd1);
    tick();
    check("to_pulse_end", 32'(bus.frame_err), 32'd0);

    // Byte arriving on the expiry cycle wins; ch1 high=0 period=20
    send_byte(8'h01); send_byte(8'h00); send_byte(8'h00);
    err_seen = 1'b0;
    for (int k = 0; k < TO_CYC - 1; k++) begin
      tick();
      if (bus.frame_err) err_seen = 1'b1;
    end
    send_byte(8'h14); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    if (bus.frame_err) err_seen = 1'b1;
    send_byte(8'hFF);
    check("to_race_err", 32'(err_seen | bus.frame_err), 32'd0);
    check("to_race_ok", 32'(bus.frame_ok), 32'd1);
    for (int k = 0; k < 210; k++) tick();
    count_level(1, 1'b1, 50, n);
    check("high0_const0", 32'(n), 32'd0);

    // ch2 high = period = 10 -> constant 1
    send_frame(64'h02_00000A_00000A_FF);
    for (int k = 0; k < 210; k++) tick();
    count_level(2, 1'b0, 50, n);
    check("full_const1", 32'(n), 32'd0);

    // ch3 period = 0 -> constant 0, then 8/4 applies the next cycle from cnt=0
    send_frame(64'h03_000000_000005_FF);
    for (int k = 0; k < 210; k++) tick();
    count_level(3, 1'b1, 30, n);
    check("per0_const0", 32'(n), 32'd0);
    send_frame(64'h03_000008_000004_FF);
    check("per0_ok", 32'(bus.frame_ok), 32'd1);
    tick();
    check("per0_still0", 32'(pwm[3]), 32'd0);
    tick();
    pat = 8'h00;
    for (int k = 0; k < 8; k++) begin
      pat = {pat[6:0], pwm[3]};
      tick();
    end
    check("per0_pattern", 32'(pat), 32'hF0);
    check("per0_next_rise", 32'(pwm[3]), 32'd1);

    // Reset mid-frame: partial frame discarded, no frame_err
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    reset = 1'b1;
    tick();
    check("midrst_err", 32'(bus.frame_err), 32'd0);
    check("midrst_pwm", 32'(pwm), 32'd0);
    tick();
    reset = 1'b0;
    tick();
    check("midrst_restart", 32'(pwm), 32'hF);
    err_seen = 1'b0;
    for (int k = 0; k < TO_CYC + 20; k++) begin
      tick();
      if (bus.frame_err) err_seen = 1'b1;
    end
    check("midrst_no_err", 32'(err_seen), 32'd0);
    send_frame(64'h00_000064_000019_FF);
    check("midrst_frame_ok", 32'(bus.frame_ok), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
